// File: rtl/bcd_ascii_serializer.sv
// Latches a packed BCD value on start and streams it out as ASCII characters,
// most-significant digit first, over a valid/ready handshake.
module bcd_ascii_serializer #(
  parameter int         DIGITS        = 3,
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [7:0] BLANK_CHAR    = 8'h20,
  parameter logic [7:0] BAD_CHAR      = 8'h3F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  start,
  output logic                  busy,
  output logic [7:0]            char_out,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic                  char_last,
  output logic                  done
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [W-1:0]     value;
  logic [IDX_W-1:0] idx;
  logic             blank;

  logic [W-1:0]     shifted;
  logic [8:0]       first_map;
  logic [8:0]       next_map;
  logic             xfer;

  // Returns {blank flag after this digit, character}.
  function automatic logic [8:0] map_digit(input logic [3:0] d,
                                           input logic       blank_in,
                                           input logic       lsd);
    if (d > 4'd9)
      return {1'b0, BAD_CHAR};
    else if (blank_in && (d == 4'd0) && !lsd)
      return {1'b1, BLANK_CHAR};
    else
      return {1'b0, 8'h30 + {4'h0, d}};
  endfunction

  // The latched value shifts left per transfer, so the digit being sent is
  // always the top nibble and the next one is the top nibble of the shift.
  always_comb begin
    shifted   = value << 4;
    first_map = map_digit(bcd_in[W-1 -: 4], BLANK_LEADING, DIGITS == 1);
    next_map  = map_digit(shifted[W-1 -: 4], blank, idx == IDX_W'(1));
    xfer      = char_valid && char_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      value      <= '0;
      idx        <= '0;
      blank      <= 1'b0;
      busy       <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            value      <= bcd_in;
            idx        <= TOP_IDX;
            blank      <= first_map[8];
            char_out   <= first_map[7:0];
            char_valid <= 1'b1;
            char_last  <= (DIGITS == 1);
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == '0) begin
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              value     <= shifted;
              idx       <= idx - 1'b1;
              blank     <= next_map[8];
              char_out  <= next_map[7:0];
              char_last <= (idx == IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Drives a blanking and a non-blanking serializer with directed and random
// values and compares every cycle against a string-level reference model.
module tb_bcd_ascii_serializer;

  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        char_ready;
  logic [11:0] bcd_in;

  logic       busy_b, valid_b, last_b, done_b;
  logic [7:0] char_b;
  logic       busy_n, valid_n, last_n, done_n;
  logic [7:0] char_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_ascii_serializer #(
    .DIGITS(DIGITS), .BLANK_LEADING(1'b1), .BLANK_CHAR(8'h20), .BAD_CHAR(8'h3F)
  ) dut_blank (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .start(start),
    .busy(busy_b), .char_out(char_b), .char_valid(valid_b),
    .char_ready(char_ready), .char_last(last_b), .done(done_b)
  );

  bcd_ascii_serializer #(
    .DIGITS(DIGITS), .BLANK_LEADING(1'b0), .BLANK_CHAR(8'h20), .BAD_CHAR(8'h3F)
  ) dut_plain (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .start(start),
    .busy(busy_n), .char_out(char_n), .char_valid(valid_n),
    .char_ready(char_ready), .char_last(last_n), .done(done_n)
  );

  // Character k (0 = most significant) of the printed string for value v.
  function automatic logic [7:0] ref_char(input logic [11:0] v, input int k,
                                          input bit blanking);
    bit         leading = blanking;
    logic [7:0] c = 8'h00;
    int         d;
    for (int i = 0; i <= k; i++) begin
      d = int'((v >> (4 * (DIGITS - 1 - i))) & 12'hF);
      if (d > 9) begin
        c = 8'h3F;
        leading = 1'b0;
      end else if (leading && d == 0 && i != DIGITS - 1) begin
        c = 8'h20;
      end else begin
        c = 8'(48 + d);
        leading = 1'b0;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag, input bit exp_done);
    chk({tag, " busy_b"},  8'(busy_b),  8'd0);
    chk({tag, " valid_b"}, 8'(valid_b), 8'd0);
    chk({tag, " last_b"},  8'(last_b),  8'd0);
    chk({tag, " done_b"},  8'(done_b),  8'(exp_done));
    chk({tag, " busy_n"},  8'(busy_n),  8'd0);
    chk({tag, " valid_n"}, 8'(valid_n), 8'd0);
    chk({tag, " last_n"},  8'(last_n),  8'd0);
    chk({tag, " done_n"},  8'(done_n),  8'(exp_done));
  endtask

  task automatic chk_char(input logic [11:0] v, input int k);
    string tag;
    tag = $sformatf("v=%03h k=%0d", v, k);
    chk({tag, " busy_b"},  8'(busy_b),  8'd1);
    chk({tag, " valid_b"}, 8'(valid_b), 8'd1);
    chk({tag, " last_b"},  8'(last_b),  8'(k == DIGITS - 1));
    chk({tag, " done_b"},  8'(done_b),  8'd0);
    chk({tag, " char_b"},  char_b,      ref_char(v, k, 1'b1));
    chk({tag, " busy_n"},  8'(busy_n),  8'd1);
    chk({tag, " valid_n"}, 8'(valid_n), 8'd1);
    chk({tag, " last_n"},  8'(last_n),  8'(k == DIGITS - 1));
    chk({tag, " done_n"},  8'(done_n),  8'd0);
    chk({tag, " char_n"},  char_n,      ref_char(v, k, 1'b0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      char_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_idle("idle", 1'b0);
    end
  endtask

  // Entered just after a negedge with the DUT idle (or in its done cycle);
  // returns at the negedge of the done cycle.
  task automatic transaction(input logic [11:0] v, input int stall_pct,
                             input bit mid_start, input logic [11:0] mid_val);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'($urandom);
    while (k < DIGITS) begin
      chk_char(v, k);
      rdy = ($urandom_range(0, 99) >= stall_pct) || (cyc > 30);
      char_ready = rdy;
      if (mid_start && cyc == 1) begin
        start  = 1'b1;
        bcd_in = mid_val;
      end
      @(negedge clk);
      start = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    chk_idle($sformatf("done v=%03h", v), 1'b1);
    char_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; char_ready = 1'b0; bcd_in = '0;
    @(negedge clk);
    chk_idle("reset", 1'b0);
    chk("reset char_b", char_b, 8'h00);
    chk("reset char_n", char_n, 8'h00);
    rst_n = 1'b1;
    idle(2);

    transaction(12'h259, 0, 1'b0, 12'h000);
    idle(2);
    transaction(12'h007, 0, 1'b0, 12'h000);
    idle(1);
    transaction(12'h000, 0, 1'b0, 12'h000);
    idle(1);
    transaction(12'h090, 0, 1'b0, 12'h000);
    idle(1);
    transaction(12'h0A5, 0, 1'b0, 12'h000);
    idle(1);

    transaction(12'h999, 50, 1'b1, 12'h123);
    transaction(12'h100, 30, 1'b0, 12'h000);
    idle(2);

    for (int i = 0; i < 20; i++) begin
      transaction(12'($urandom_range(0, 4095)), $urandom_range(0, 60), 1'b0, 12'h000);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    // Reset in the middle of a sequence.
    bcd_in = 12'h456; start = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_char(12'h456, 0);
    @(negedge clk);
    chk_char(12'h456, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("async reset", 1'b0);
    chk("async reset char_b", char_b, 8'h00);
    chk("async reset char_n", char_n, 8'h00);
    @(negedge clk);
    chk_idle("in reset", 1'b0);
    rst_n = 1'b1;
    idle(4);

    transaction(12'h321, 20, 1'b0, 12'h000);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_serializer.md
Name: bcd_ascii_serializer

Overview:
- Downstream stage of the 3-digit BCD incrementer.
- Captures a packed BCD value on request and emits it as ASCII characters, most-significant digit first, one character per valid/ready handshake.
- Characters go to the 12864 LCD text-write path.
- Supports optional leading-zero blanking and flags non-decimal nibbles.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in (>=1).
- BLANK_LEADING, 1, 1 = replace leading zeros with BLANK_CHAR; 0 = print all digits.
- BLANK_CHAR, 8'h20, character emitted for a blanked leading zero.
- BAD_CHAR, 8'h3F, character emitted for a nibble > 9.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bcd_in  in  4*DIGITS  packed BCD value; digit DIGITS-1 in MS nibble.
- start  in  1  request to capture bcd_in and begin emitting.
- busy  out  1  high from the cycle after start is accepted until the final transfer completes.
- char_out  out  8  ASCII character.
- char_valid  out  1  char_out is valid.
- char_ready  in  1  consumer accepts char_out when high together with char_valid.
- char_last  out  1  high with char_valid on the final (least-significant) character.
- done  out  1  one-cycle pulse in the cycle after the final transfer.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, char_valid, char_last, done = 0; char_out = 8'h00; latched value and index cleared. Assertion mid-operation aborts immediately with no further characters or done pulse.
- States:
  - IDLE -> SEND on start.
  - SEND -> SEND on a non-final transfer.
  - SEND -> IDLE on the final transfer.
- IDLE:
  - start=1 latches bcd_in into an internal register and sets index = DIGITS-1.
  - The blank flag is set to BLANK_LEADING.
  - Next cycle: busy=1, char_valid=1, char_out = character for the MS digit. Latency from start to first char_valid is 1 cycle.
- Character mapping for digit d at the current index:
  - d > 9: BAD_CHAR; clears the blank flag.
  - blank flag set, d == 0, and index != 0: BLANK_CHAR.
  - Otherwise 8'h30 + d; clears the blank flag.
  - The least-significant digit is never blanked, so a value of 0 prints "  0".
- SEND:
  - char_out, char_valid and char_last are held stable while char_valid=1 and char_ready=0. A transfer occurs when char_valid && char_ready.
  - Transfer with index > 0: index decrements, next character presented on the following cycle. Back-to-back transfers sustain 1 character/cycle while char_ready is held high.
  - char_last=1 exactly when index == 0.
  - Transfer with index == 0: next cycle char_valid=0, char_last=0, busy=0, done=1 for one cycle, state IDLE.
- start while busy=1 is ignored; the latched value is unaffected by bcd_in changes after capture.
- start in the done cycle is accepted (state already IDLE); the first character of the new value appears the following cycle. done still pulses exactly once for the previous value.
- char_ready while char_valid=0 has no effect.
- Exactly DIGITS transfers per accepted start.

Test Plan:
- Reset, then bcd_in=12'h259, start pulse, char_ready=1 -> chars 8'h32,8'h35,8'h39 on 3 consecutive cycles starting 1 cycle after start; char_last only on 8'h39; done pulses once the cycle after; busy returns to 0.
- BLANK_LEADING=1, bcd_in=12'h007 -> 8'h20,8'h20,8'h37. bcd_in=12'h000 -> 8'h20,8'h20,8'h30. bcd_in=12'h090 -> 8'h20,8'h39,8'h30 (interior zero printed).
- BLANK_LEADING=0, bcd_in=12'h007 -> 8'h30,8'h30,8'h37.
- bcd_in=12'h0A5 with blanking -> 8'h20,8'h3F,8'h35.
- bcd_in=12'h999, char_ready toggling 0/1 with random stalls:
  - char_out/char_valid/char_last stable during stalls.
  - Exactly 3 transfers.
  - Second start mid-sequence with bcd_in=12'h123 ignored.
  - start in the done cycle with 12'h100 -> 8'h31,8'h30,8'h30.
- Assert rst_n=0 after the first transfer of 12'h456 -> outputs 0 asynchronously; no done pulse; after release, idle until next start.
